// File: rtl/rv_imm_pkg.sv
// Shared RISC-V immediate-format definitions: immsrc codes and the per-format field masks.
// Kept in one place so the immediate encoder and the decoder/extender agree bit for bit.
package rv_imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;

    // Illegal formats own no bits, so the base word passes through untouched.
    function automatic logic [31:0] imm_mask(input logic [2:0] src);
        case (src)
            IMM_I:   return MASK_I;
            IMM_S:   return MASK_S;
            IMM_B:   return MASK_B;
            IMM_J:   return MASK_J;
            IMM_U:   return MASK_U;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate scatter into I/S/B/J/U fields plus error flag.
// Range checking is compiled in with INSTR_PACKER_RANGE_CHECK_EN.
module imm_pack
    import rv_imm_pkg::*;
(
    input  logic [31:0] base_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  immsrc_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic [31:0] fields;
    logic        legal;
    logic        range_err;

    always_comb begin
        fields = 32'h0;
        legal  = 1'b1;
        case (immsrc_i)
            IMM_I:   fields = {imm_i[11:0], 20'h0};
            IMM_S:   fields = {imm_i[11:5], 13'h0, imm_i[4:0], 7'h0};
            IMM_B:   fields = {imm_i[12], imm_i[10:5], 13'h0, imm_i[4:1], imm_i[11], 7'h0};
            IMM_J:   fields = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h0};
            IMM_U:   fields = {imm_i[31:12], 12'h0};
            default: legal = 1'b0;
        endcase
    end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
    // Flag values whose dropped upper/lower bits would change the encoded immediate.
    always_comb begin
        range_err = 1'b0;
        case (immsrc_i)
            IMM_I, IMM_S: range_err = imm_i[31:11] != {21{imm_i[31]}};
            IMM_B:        range_err = (imm_i[31:12] != {20{imm_i[31]}}) || imm_i[0];
            IMM_J:        range_err = (imm_i[31:20] != {12{imm_i[31]}}) || imm_i[0];
            IMM_U:        range_err = |imm_i[11:0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign instr_o = (base_i & ~imm_mask(immsrc_i)) | fields;
    assign err_o   = !legal || range_err;

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: one output register stage with valid/ready handshake, sequential imem
// word address and sticky wrap flag. Range errors are enabled by INSTR_PACKER_RANGE_CHECK_EN.
module instr_packer
    import rv_imm_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_immsrc_i,
    input  logic [31:0]       in_imm_i,
    input  logic [31:0]       in_base_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_err_o,
    output logic              wrapped_o
);

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

    logic [31:0]       pack_instr;
    logic              pack_err;
    logic              in_hs;
    logic              out_hs;
    logic [ADDR_W-1:0] addr_inc;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;

    imm_pack u_imm_pack (
        .base_i   (in_base_i),
        .imm_i    (in_imm_i),
        .immsrc_i (in_immsrc_i),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    assign in_ready_o = !wrapped_q && (!valid_q || out_ready_i);
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = valid_q && out_ready_i;
    assign addr_inc   = addr_q + 1'b1;

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        if (out_hs) begin
            valid_d = 1'b0;
        end
        if (in_hs) begin
            valid_d = 1'b1;
            instr_d = pack_instr;
            err_d   = pack_err;
        end
        // clr wins over the increment; a pending word simply takes StartAddr.
        if (clr_i) begin
            addr_d    = StartAddr;
            wrapped_d = 1'b0;
        end else if (out_hs) begin
            addr_d = addr_inc;
            if (addr_inc == StartAddr) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            instr_q   <= 32'h0;
            err_q     <= 1'b0;
            addr_q    <= StartAddr;
            wrapped_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_instr_o = instr_q;
    assign out_err_o   = err_q;
    assign out_addr_o  = addr_q;
    assign wrapped_o   = wrapped_q;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: directed vectors, wrap/stall/reset scenarios and a
// randomized stream checked against a transaction-level reference model.
module tb_instr_packer;

    localparam int unsigned AW = 2;
    localparam int unsigned SA = 0;
    localparam int unsigned NW = 1 << AW;
`ifdef INSTR_PACKER_RANGE_CHECK_EN
    localparam bit RangeEn = 1'b1;
`else
    localparam bit RangeEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    in_immsrc = 3'd0;
    logic [31:0]   in_imm = 32'h0;
    logic [31:0]   in_base = 32'h0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;
    logic          wrapped;

    int checks = 0;
    int failures = 0;

    word_t       exp_q[$];
    int unsigned m_addr = SA;
    bit          m_wrapped = 1'b0;
    bit          m_rdy;
    bit          m_hs;
    word_t       wv;

    instr_packer #(
        .ADDR_W     (AW),
        .START_ADDR (SA)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_immsrc_i (in_immsrc),
        .in_imm_i    (in_imm),
        .in_base_i   (in_base),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_instr_o (out_instr),
        .out_addr_o  (out_addr),
        .out_err_o   (out_err),
        .wrapped_o   (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoding from the field tables, using shifts/masks and signed ranges.
    function automatic word_t model_pack(input logic [2:0] src, input logic [31:0] imm,
                                         input logic [31:0] base);
        word_t  w;
        longint s;
        bit     rerr;
        s     = longint'($signed(imm));
        rerr  = 1'b0;
        w.err = 1'b0;
        case (src)
            3'd0: begin
                w.instr = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
                rerr = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                w.instr = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25)
                        | ((imm & 32'h1F) << 7);
                rerr = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w.instr = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                        | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                        | (((imm >> 11) & 32'h1) << 7);
                rerr = (s < -4096) || (s > 4095) || ((imm % 2) != 0);
            end
            3'd3: begin
                w.instr = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                        | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                        | (((imm >> 12) & 32'hFF) << 12);
                rerr = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || ((imm % 2) != 0);
            end
            3'd4: begin
                w.instr = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
                rerr = (imm % 4096) != 0;
            end
            default: begin
                w.instr = base;
                w.err   = 1'b1;
            end
        endcase
        if (src <= 3'd4 && RangeEn) w.err = rerr;
        return w;
    endfunction

    task automatic drive_rand();
        in_immsrc = 3'($urandom_range(0, 7));
        in_base   = $urandom;
        case ($urandom_range(0, 3))
            0: in_imm = $urandom;
            1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: in_imm = $urandom << 12;
            default: in_imm = (32'($urandom_range(0, (1 << 21) - 1)) - 32'h0010_0000) & ~32'h1;
        endcase
    endtask

    // Cycle scoreboard: compare at negedge, then advance the model by the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_addr    = SA;
            m_wrapped = 1'b0;
        end else begin
            m_rdy = !m_wrapped && (exp_q.size() == 0 || out_ready);
            check_eq("in_ready", 32'(in_ready), 32'(m_rdy));
            check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check_eq("wrapped", 32'(wrapped), 32'(m_wrapped));
            check_eq("out_addr", 32'(out_addr), m_addr);
            if (exp_q.size() != 0) begin
                check_eq("out_instr", out_instr, exp_q[0].instr);
                check_eq("out_err", 32'(out_err), 32'(exp_q[0].err));
            end
            m_hs = (exp_q.size() != 0) && out_ready;
            if (m_hs) void'(exp_q.pop_front());
            if (clr) begin
                m_addr    = SA;
                m_wrapped = 1'b0;
            end else if (m_hs) begin
                m_addr = (m_addr + 1) % NW;
                if (m_addr == SA) m_wrapped = 1'b1;
            end
            if (in_valid && m_rdy) exp_q.push_back(model_pack(in_immsrc, in_imm, in_base));
        end
    end

    logic [2:0]  d_src [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
    logic [31:0] d_imm [7] = '{32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFC, 32'd8, 32'h1234_5000,
                               32'd2048, 32'd5};
    logic [31:0] d_base[7] = '{32'h13, 32'h0020_2023, 32'h63, 32'hEF, 32'h37, 32'h13,
                               32'h0000_1234};
    logic [31:0] d_exp [7] = '{32'hFFF0_0013, 32'h0020_2423, 32'hFE00_0EE3, 32'h0080_00EF,
                               32'h1234_5037, 32'h8000_0013, 32'h0000_1234};
    bit          d_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RangeEn, 1'b1};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_err", 32'(out_err), 32'd0);
        check_eq("rst_addr", 32'(out_addr), SA);
        check_eq("rst_wrapped", 32'(wrapped), 32'd0);
        rst_n = 1'b1;

        // Directed encodings, each from a freshly cleared counter.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
            in_immsrc = d_src[i]; in_imm = d_imm[i]; in_base = d_base[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check_eq($sformatf("dir%0d_valid", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("dir%0d_instr", i), out_instr, d_exp[i]);
            check_eq($sformatf("dir%0d_err", i), 32'(out_err), 32'(d_err[i]));
            check_eq($sformatf("dir%0d_addr", i), 32'(out_addr), SA);
        end

        // Four back-to-back words fill the address space and set wrapped.
        @(posedge clk); #1;
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            drive_rand();
            @(posedge clk); #1;
            check_eq("bb_valid", 32'(out_valid), 32'd1);
            check_eq("bb_addr", 32'(out_addr), 32'(k));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("wrap_flag", 32'(wrapped), 32'd1);
        check_eq("wrap_ready", 32'(in_ready), 32'd0);
        check_eq("wrap_valid", 32'(out_valid), 32'd0);

        // Clear, then stall a pending word for three cycles.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check_eq("clr_wrapped", 32'(wrapped), 32'd0);
        check_eq("clr_addr", 32'(out_addr), SA);
        out_ready = 1'b0; in_valid = 1'b1;
        in_immsrc = 3'd2; in_imm = 32'hFFFF_F000; in_base = $urandom;
        wv = model_pack(in_immsrc, in_imm, in_base);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_instr", out_instr, wv.instr);
            check_eq("hold_err", 32'(out_err), 32'(wv.err));
            check_eq("hold_addr", 32'(out_addr), SA);
        end
        out_ready = 1'b1;

        // Move the address off START_ADDR, leave a word pending, then reset mid-cycle.
        in_valid = 1'b1;
        drive_rand();
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_rand();
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_addr", 32'(out_addr), SA);
        check_eq("arst_instr", out_instr, 32'h0);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);

        // Randomized traffic with back-pressure and occasional clr.
        repeat (500) begin
            @(posedge clk); #1;
            clr       = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            drive_rand();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
